// File: rtl/adc_channel_averager.sv
// rtl/adc_channel_averager.sv - single-channel boxcar averager for the ADC response stream
// Optional ADC_AVG_MINMAX_EN adds per-window min/max capture on avg_min/avg_max.
module adc_channel_averager #(
    parameter int DATA_W   = 12,
    parameter int CH_W     = 5,
    parameter int CHANNEL  = 1,
    parameter int AVG_LOG2 = 4
) (
    input  logic              clk_clk,
    input  logic              reset_reset,
    input  logic              en,
    input  logic              rsp_valid,
    input  logic [CH_W-1:0]   rsp_channel,
    input  logic [DATA_W-1:0] rsp_data,
    output logic              avg_valid,
    input  logic              avg_ready,
    output logic [DATA_W-1:0] avg_data,
    output logic              ovf,
    input  logic              ovf_clr,
    output logic [2:0]        led_level,
    output logic [DATA_W-1:0] avg_min,
    output logic [DATA_W-1:0] avg_max
);

    localparam int ACC_W = DATA_W + AVG_LOG2;
    localparam int CNT_W = (AVG_LOG2 == 0) ? 1 : AVG_LOG2;
    localparam int WIN   = 1 << AVG_LOG2;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIN - 1);

    logic [ACC_W-1:0]  r_acc;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_avg_valid;
    logic [DATA_W-1:0] r_avg_data;
    logic              r_ovf;
    logic [2:0]        r_led;

    logic              w_accept;
    logic              w_last;
    logic              w_load;
    logic [ACC_W-1:0]  w_sum;
    logic [ACC_W-1:0]  w_shift;
    logic [DATA_W-1:0] w_avg;
    logic [2:0]        w_led;

    assign w_accept = rsp_valid & en & (rsp_channel == CH_W'(CHANNEL));
    assign w_last   = (r_cnt == CNT_LAST);
    assign w_load   = w_accept & w_last;
    assign w_sum    = r_acc + ACC_W'(rsp_data);
    assign w_shift  = w_sum >> AVG_LOG2;
    assign w_avg    = w_shift[DATA_W-1:0];

    always_comb begin
        w_led = 3'b000;
        case (w_avg[DATA_W-1 -: 2])
            2'd0:    w_led = 3'b000;
            2'd1:    w_led = 3'b001;
            2'd2:    w_led = 3'b011;
            default: w_led = 3'b111;
        endcase
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            r_avg_valid <= 1'b0;
            r_avg_data  <= '0;
            r_ovf       <= 1'b0;
            r_led       <= 3'b000;
        end else begin
            if (!en) begin
                r_acc <= '0;
                r_cnt <= '0;
            end else if (w_accept) begin
                if (w_last) begin
                    r_acc <= '0;
                    r_cnt <= '0;
                end else begin
                    r_acc <= w_sum;
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end

            // A load in the handshake cycle keeps valid high with the fresh value.
            if (w_load) begin
                r_avg_valid <= 1'b1;
                r_avg_data  <= w_avg;
                r_led       <= w_led;
            end else if (r_avg_valid && avg_ready) begin
                r_avg_valid <= 1'b0;
            end

            // Set has priority over a same-cycle clear.
            if (w_load && r_avg_valid && !avg_ready) begin
                r_ovf <= 1'b1;
            end else if (ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign avg_valid = r_avg_valid;
    assign avg_data  = r_avg_data;
    assign ovf       = r_ovf;
    assign led_level = r_led;

`ifdef ADC_AVG_MINMAX_EN
    logic [DATA_W-1:0] r_run_min;
    logic [DATA_W-1:0] r_run_max;
    logic [DATA_W-1:0] r_avg_min;
    logic [DATA_W-1:0] r_avg_max;
    logic [DATA_W-1:0] w_new_min;
    logic [DATA_W-1:0] w_new_max;
    logic              w_first;

    // The first sample of a window restarts both running extremes.
    assign w_first   = (r_cnt == '0);
    assign w_new_min = (w_first || (rsp_data < r_run_min)) ? rsp_data : r_run_min;
    assign w_new_max = (w_first || (rsp_data > r_run_max)) ? rsp_data : r_run_max;

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_run_min <= '0;
            r_run_max <= '0;
            r_avg_min <= '0;
            r_avg_max <= '0;
        end else begin
            if (!en) begin
                r_run_min <= '0;
                r_run_max <= '0;
            end else if (w_accept) begin
                r_run_min <= w_new_min;
                r_run_max <= w_new_max;
            end
            if (w_load) begin
                r_avg_min <= w_new_min;
                r_avg_max <= w_new_max;
            end
        end
    end

    assign avg_min = r_avg_min;
    assign avg_max = r_avg_max;
`else
    assign avg_min = '0;
    assign avg_max = '0;
`endif

endmodule

// File: tb/tb_adc_channel_averager.sv
// tb/tb_adc_channel_averager.sv - directed self-checking bench for adc_channel_averager
module tb_adc_channel_averager;

    logic        clk_clk;
    logic        reset_reset;
    logic        en;
    logic        rsp_valid;
    logic [4:0]  rsp_channel;
    logic [11:0] rsp_data;
    logic        avg_valid;
    logic        avg_ready;
    logic [11:0] avg_data;
    logic        ovf;
    logic        ovf_clr;
    logic [2:0]  led_level;
    logic [11:0] avg_min;
    logic [11:0] avg_max;

    int checks = 0;
    int errors = 0;
    int hs_cnt = 0;
    int hs_base;

    adc_channel_averager dut (
        .clk_clk     (clk_clk),
        .reset_reset (reset_reset),
        .en          (en),
        .rsp_valid   (rsp_valid),
        .rsp_channel (rsp_channel),
        .rsp_data    (rsp_data),
        .avg_valid   (avg_valid),
        .avg_ready   (avg_ready),
        .avg_data    (avg_data),
        .ovf         (ovf),
        .ovf_clr     (ovf_clr),
        .led_level   (led_level),
        .avg_min     (avg_min),
        .avg_max     (avg_max)
    );

    initial clk_clk = 1'b0;
    always #5 clk_clk = ~clk_clk;

    always @(posedge clk_clk) begin
        if (!reset_reset && avg_valid && avg_ready) hs_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [4:0] ch, input logic [11:0] d, input logic clr);
        @(negedge clk_clk);
        rsp_valid   = 1'b1;
        rsp_channel = ch;
        rsp_data    = d;
        ovf_clr     = clr;
        @(negedge clk_clk);
        rsp_valid   = 1'b0;
        ovf_clr     = 1'b0;
    endtask

    task automatic check_minmax(input string tag, input logic [11:0] mn, input logic [11:0] mx);
`ifdef ADC_AVG_MINMAX_EN
        check({tag, "_min"}, 32'(avg_min), 32'(mn));
        check({tag, "_max"}, 32'(avg_max), 32'(mx));
`else
        check({tag, "_min"}, 32'(avg_min), 32'(mn & 12'h000));
        check({tag, "_max"}, 32'(avg_max), 32'(mx & 12'h000));
`endif
    endtask

    initial begin
        reset_reset = 1'b1;
        en          = 1'b1;
        rsp_valid   = 1'b0;
        rsp_channel = 5'd0;
        rsp_data    = 12'h000;
        avg_ready   = 1'b1;
        ovf_clr     = 1'b0;
        repeat (3) @(negedge clk_clk);
        check("rst_valid", 32'(avg_valid), 32'd0);
        check("rst_data",  32'(avg_data),  32'd0);
        check("rst_ovf",   32'(ovf),       32'd0);
        check("rst_led",   32'(led_level), 32'd0);
        check("rst_min",   32'(avg_min),   32'd0);
        check("rst_max",   32'(avg_max),   32'd0);
        reset_reset = 1'b0;

        // Constant 0x800 window
        hs_base = hs_cnt;
        for (int i = 0; i < 15; i++) send(5'd1, 12'h800, 1'b0);
        check("c800_early_valid", 32'(avg_valid), 32'd0);
        send(5'd1, 12'h800, 1'b0);
        check("c800_valid", 32'(avg_valid), 32'd1);
        check("c800_data",  32'(avg_data),  32'h800);
        check("c800_led",   32'(led_level), 32'b011);
        check_minmax("c800", 12'h800, 12'h800);
        @(negedge clk_clk);
        check("c800_drop", 32'(avg_valid), 32'd0);
        check("c800_hs",   32'(hs_cnt - hs_base), 32'd1);

        // Ramp 0..15
        for (int i = 0; i < 16; i++) send(5'd1, 12'(i), 1'b0);
        check("ramp_data", 32'(avg_data),  32'd7);
        check("ramp_led",  32'(led_level), 32'b000);
        check_minmax("ramp", 12'd0, 12'd15);

        // Interleaved channels; ch 2 must be ignored
        for (int i = 0; i < 16; i++) begin
            send(5'd1, 12'hFFF, 1'b0);
            send(5'd2, 12'h000, 1'b0);
        end
        check("intl_data", 32'(avg_data),  32'hFFF);
        check("intl_led",  32'(led_level), 32'b111);
        check_minmax("intl", 12'hFFF, 12'hFFF);
        @(negedge clk_clk);

        // Overwrite with no consumer
        avg_ready = 1'b0;
        for (int i = 0; i < 16; i++) send(5'd1, 12'h400, 1'b0);
        check("ovw_first_data", 32'(avg_data), 32'h400);
        check("ovw_first_ovf",  32'(ovf),      32'd0);
        for (int i = 0; i < 16; i++) send(5'd1, 12'hC00, 1'b0);
        check("ovw_data",  32'(avg_data), 32'hC00);
        check("ovw_valid", 32'(avg_valid), 32'd1);
        check("ovw_ovf",   32'(ovf),       32'd1);
        ovf_clr = 1'b1;
        @(negedge clk_clk);
        ovf_clr = 1'b0;
        check("ovw_clr", 32'(ovf), 32'd0);

        // Overflow set and clear in the same cycle: set wins
        for (int i = 0; i < 15; i++) send(5'd1, 12'h300, 1'b0);
        check("setclr_pre_ovf", 32'(ovf), 32'd0);
        send(5'd1, 12'h300, 1'b1);
        check("setclr_ovf",  32'(ovf),      32'd1);
        check("setclr_data", 32'(avg_data), 32'h300);
        ovf_clr = 1'b1;
        @(negedge clk_clk);
        ovf_clr   = 1'b0;
        avg_ready = 1'b1;
        @(negedge clk_clk);
        check("drain_valid", 32'(avg_valid), 32'd0);

        // Reset mid-window
        for (int i = 0; i < 8; i++) send(5'd1, 12'hFFF, 1'b0);
        reset_reset = 1'b1;
        @(negedge clk_clk);
        reset_reset = 1'b0;
        check("midrst_data", 32'(avg_data), 32'd0);
        for (int i = 0; i < 16; i++) send(5'd1, 12'h100, 1'b0);
        check("midrst_avg", 32'(avg_data), 32'h100);
        check("midrst_ovf", 32'(ovf),      32'd0);
        check_minmax("midrst", 12'h100, 12'h100);
        @(negedge clk_clk);

        // en=0 mid-window discards the partial window
        hs_base = hs_cnt;
        for (int i = 0; i < 8; i++) send(5'd1, 12'hFFF, 1'b0);
        en = 1'b0;
        @(negedge clk_clk);
        en = 1'b1;
        for (int i = 0; i < 15; i++) send(5'd1, 12'h200, 1'b0);
        check("en_early_hs", 32'(hs_cnt - hs_base), 32'd0);
        send(5'd1, 12'h200, 1'b0);
        check("en_avg", 32'(avg_data), 32'h200);
        check_minmax("en", 12'h200, 12'h200);
        repeat (3) @(negedge clk_clk);
        check("en_hs", 32'(hs_cnt - hs_base), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
